// File: rtl/axi_axis2bram.sv
// axi_axis2bram: receives a fixed-length AXI4-Stream transfer and writes each
// beat to consecutive BRAM words starting at address 0. A sticky flag records
// any disagreement between the programmed length and the tlast marker.
module axi_axis2bram #(
    parameter int AXI_DATA_WIDTH      = 128,
    parameter int AXI_XFER_SIZE_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH     = 32,
    parameter int BRAM_DATA_WIDTH     = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_as2b_start,
    output logic                           o_as2b_done,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_as2b_data_size_bytes,
    output logic                           o_as2b_len_err,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [AXI_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                           s_axis_tlast,
    output logic                           o_as2b_wren,
    output logic [BRAM_ADDR_WIDTH-1:0]     o_as2b_wraddr,
    output logic [BRAM_DATA_WIDTH-1:0]     o_as2b_wrdata
);
    // Depth is carried 4 bits wider than the byte count so the *8 never overflows.
    localparam int DW = AXI_XFER_SIZE_WIDTH + 4;
    localparam int CNTW = BRAM_ADDR_WIDTH + 1;
    // Common width for comparing the beat counter against the depth.
    localparam int CW = (DW > CNTW) ? DW : CNTW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DW-1:0]              r_depth;
    logic [CNTW-1:0]            r_cnt;
    logic                       r_len_err;
    logic                       r_wren;
    logic [BRAM_ADDR_WIDTH-1:0] r_wraddr;
    logic [BRAM_DATA_WIDTH-1:0] r_wrdata;

    logic [DW-1:0]              w_bits;
    logic [DW-1:0]              w_depth;
    logic [CW-1:0]              w_cnt_ext;
    logic [CW-1:0]              w_last_idx;
    logic                       w_start_ok;
    logic                       w_hs;
    logic                       w_at_end;
    logic                       w_term;

    assign w_bits     = {4'b0, i_as2b_data_size_bytes} << 3;
    assign w_depth    = w_bits / DW'(BRAM_DATA_WIDTH);
    assign w_cnt_ext  = CW'(r_cnt);
    // Only consulted in BUSY, where depth is known to be non-zero.
    assign w_last_idx = CW'(r_depth) - CW'(1);
    assign w_start_ok = (r_state == S_IDLE) && i_as2b_start;
    assign w_hs       = s_axis_tvalid && s_axis_tready;
    assign w_at_end   = (w_cnt_ext == w_last_idx);
    assign w_term     = w_hs && (w_at_end || s_axis_tlast);

    // Handshaking and status decode straight from the state register.
    assign s_axis_tready  = (r_state == S_BUSY);
    assign o_as2b_done    = (r_state == S_IDLE);
    assign o_as2b_len_err = r_len_err;
    assign o_as2b_wren    = r_wren;
    assign o_as2b_wraddr  = r_wraddr;
    assign o_as2b_wrdata  = r_wrdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: a zero-depth start never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_as2b_start && (w_depth != '0)) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_term) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: depth capture, beat counter and sticky length error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth   <= '0;
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_depth   <= w_depth;
                r_cnt     <= '0;
                r_len_err <= 1'b0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + CNTW'(1);
                // Short stream (early tlast) or long/unmarked stream (no tlast at end).
                if ((s_axis_tlast && (w_cnt_ext < w_last_idx)) || (w_at_end && !s_axis_tlast))
                    r_len_err <= 1'b1;
            end
        end
    end

    // Registered BRAM write port; address/data hold when no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
        end else begin
            r_wren <= w_hs;
            if (w_hs) begin
                r_wraddr <= r_cnt[BRAM_ADDR_WIDTH-1:0];
                r_wrdata <= s_axis_tdata;
            end
        end
    end
endmodule
